// File: rtl/ascon_output_serializer.sv
// ascon_output_serializer: buffers Ascon cipher blocks and the tag, then streams them as 32-bit words.
// Cipher blocks always drain ahead of the tag; sticky flags report drops and out-of-order sequences.
module ascon_output_serializer (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_sys_enable,
    input  logic         i_start,
    input  logic [63:0]  i_cipher,
    input  logic         i_valid_cipher,
    input  logic [127:0] i_tag,
    input  logic         i_done,
    input  logic         i_ready,
    output logic [31:0]  o_data,
    output logic         o_valid,
    output logic         o_is_tag,
    output logic         o_last,
    output logic         o_overflow,
    output logic         o_seq_error
);
    typedef enum logic [1:0] {IDLE, CIPHER_HI, CIPHER_LO, TAG} state_t;
    state_t       state;
    logic         capture_c, capture_t;
    logic [63:0]  fifo [4];
    logic [1:0]   wr_ptr, rd_ptr, tag_idx;
    logic [2:0]   count, blk_count;
    logic [127:0] tag;
    logic         tag_pending;
    logic         pop, push, full, tag_done;
    logic [63:0]  head;
    assign head     = fifo[rd_ptr];
    assign full     = count == 3'd4;
    assign pop      = state == CIPHER_LO && i_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push     = capture_c && (!full || pop);
    assign tag_done = state == TAG && i_ready && tag_idx == 2'd3;
    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr] <= i_cipher;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || !i_sys_enable) begin
            state       <= IDLE;
            capture_c   <= 1'b0;
            capture_t   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_idx     <= '0;
            count       <= '0;
            blk_count   <= '0;
            tag         <= '0;
            tag_pending <= 1'b0;
            o_overflow  <= 1'b0;
            o_seq_error <= 1'b0;
        end else begin
            capture_c <= i_valid_cipher;
            capture_t <= i_done;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
            if (capture_t) tag <= i_tag;
            tag_pending <= capture_t || (tag_pending && !tag_done);
            if (i_start) begin
                blk_count   <= '0;
                o_overflow  <= 1'b0;
                o_seq_error <= 1'b0;
            end else begin
                if (capture_c && blk_count != 3'd7) blk_count <= blk_count + 3'd1;
                if ((capture_c && !push) || (capture_t && tag_pending)) o_overflow <= 1'b1;
                if ((capture_c && blk_count == 3'd4) || (capture_t && blk_count != 3'd4)) o_seq_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    tag_idx <= '0;
                    if (count != 3'd0) state <= CIPHER_HI;
                    else if (tag_pending) state <= TAG;
                end
                CIPHER_HI: if (i_ready) state <= CIPHER_LO;
                CIPHER_LO: begin
                    tag_idx <= '0;
                    if (i_ready) state <= (count > 3'd1 || push) ? CIPHER_HI : tag_pending ? TAG : IDLE;
                end
                TAG: if (i_ready) begin
                    tag_idx <= tag_idx + 2'd1;
                    if (tag_idx == 2'd3) state <= IDLE;
                end
            endcase
        end
    end
    always_comb begin
        o_valid  = state != IDLE;
        o_is_tag = state == TAG;
        o_last   = state == TAG && tag_idx == 2'd3;
        o_data   = state == CIPHER_HI ? head[63:32] :
                   state == CIPHER_LO ? head[31:0] :
                   state == TAG       ? tag[{~tag_idx, 5'd0} +: 32] : '0;
    end
endmodule
